uart_frame_tx: RTL and testbench

//  Parametrised successor to the fixed 18-channel sampler/UART transmitter. Samples NUM_CH

---
 rtl/uart_frame_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Latches NUM_CH single-bit channels at the start of each frame and sends them
//   LSB-first as one UART frame: start bit, NUM_CH data bits, optional even
//   parity, then STOP_BITS stop bits. While uart_start stays high, a new frame
//   begins every PERIOD_BITS bit-times, measured from one start edge to the next.
//
// Ports
//   sys_clk        in   system clock
//   sys_reset      in   asynchronous, active-high reset
//   uart_start     in   level; 1 = keep sending frames periodically
//   ch_in          in   [NUM_CH-1:0] channel inputs, ch_in[0] is sent first
//   uart_txd       out  serial line, idles high
//   tx_busy        out  high from the start bit through the last stop bit
//   sample_strobe  out  1-cycle pulse in the cycle after ch_in is latched
//   uart_done      out  1-cycle pulse on the last cycle of the final stop bit
//
// Handshake: none. uart_start is a level request sampled on every edge in IDLE
// and once more at the end of each period; every output is a flop.
module uart_frame_tx #(
  parameter int NUM_CH       = 18,
  parameter int CLKS_PER_BIT = 576,
  parameter int PERIOD_BITS  = 32,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              uart_start,
  input  logic [NUM_CH-1:0] ch_in,
  output logic              uart_txd,
  output logic              tx_busy,
  output logic              sample_strobe,
  output logic              uart_done
);

  localparam int FRAME_BITS = 1 + NUM_CH + PARITY_EN + STOP_BITS;
  localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int PER_W      = $clog2(PERIOD_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST    = BIT_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST    = BIT_W'(STOP_BITS - 1);
  localparam logic [PER_W-1:0]  PER_LAST     = PER_W'(PERIOD_BITS - 1);

  if (PERIOD_BITS < FRAME_BITS || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CLKS_PER_BIT < 2 || NUM_CH < 1 || NUM_CH > 64) begin : g_bad_params
    $error("uart_frame_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;     // index within DATA or STOP
  logic [PER_W-1:0]    per_q, per_d;     // bit-times since the frame's start edge
  logic [NUM_CH-1:0]   shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic                txd_d, busy_d, strobe_d, done_d;
  logic                tick, launch, period_end;

  assign tick = (baud_q == BAUD_LAST);

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      per_q         <= '0;
      shreg_q       <= '0;
      parity_q      <= 1'b0;
      uart_txd      <= 1'b1;
      tx_busy       <= 1'b0;
      sample_strobe <= 1'b0;
      uart_done     <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      per_q         <= per_d;
      shreg_q       <= shreg_d;
      parity_q      <= parity_d;
      uart_txd      <= txd_d;
      tx_busy       <= busy_d;
      sample_strobe <= strobe_d;
      uart_done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    per_d      = per_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    launch     = 1'b0;
    period_end = 1'b0;

    if (state_q != ST_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: launch = uart_start;
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          per_d   = per_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          per_d   = per_q + 1'b1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
          per_d   = per_q + 1'b1;
        end
      end
      ST_STOP: begin
        // uart_done is a flop, so it is armed one cycle ahead of the last stop cycle.
        if (bit_q == STOP_LAST && baud_q == BAUD_PRELAST) done_d = 1'b1;
        if (tick) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 1'b1;
            per_d = per_q + 1'b1;
          end else if (per_q == PER_LAST) begin
            period_end = 1'b1;   // frame fills the whole period: no gap
          end else begin
            state_d = ST_GAP;
            bit_d   = '0;
            per_d   = per_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (per_q == PER_LAST) period_end = 1'b1;
          else                   per_d = per_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (period_end) begin
      launch  = uart_start;
      state_d = ST_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      per_d   = '0;
    end

    if (launch) begin
      state_d  = ST_START;
      baud_d   = '0;
      bit_d    = '0;
      per_d    = '0;
      shreg_d  = ch_in;
      parity_d = ^ch_in;
      strobe_d = 1'b1;
    end

    // Line and busy are registered from the state being entered, so they
    // change on the same edge as the FSM.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = parity_d;
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_d == ST_START) || (state_d == ST_DATA) ||
             (state_d == ST_PARITY) || (state_d == ST_STOP);
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // dut_a: 4 ch, 4 clk/bit, period 8, no parity (frame 6 bits)
  logic       start_a = 1'b0;
  logic [3:0] ch_a    = '0;
  logic       txd_a, busy_a, strobe_a, done_a;
  // dut_p: even parity (frame 7 bits), period 8
  logic       start_p = 1'b0;
  logic [3:0] ch_p    = '0;
  logic       txd_p, busy_p, strobe_p, done_p;
  // dut_b: period equals frame length (back-to-back)
  logic       start_b = 1'b0;
  logic [3:0] ch_b    = '0;
  logic       txd_b, busy_b, strobe_b, done_b;

  uart_frame_tx #(.NUM_CH(4), .CLKS_PER_BIT(4), .PERIOD_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .sys_clk(clk), .sys_reset(rst), .uart_start(start_a), .ch_in(ch_a),
    .uart_txd(txd_a), .tx_busy(busy_a), .sample_strobe(strobe_a), .uart_done(done_a));

  uart_frame_tx #(.NUM_CH(4), .CLKS_PER_BIT(4), .PERIOD_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dut_p (
    .sys_clk(clk), .sys_reset(rst), .uart_start(start_p), .ch_in(ch_p),
    .uart_txd(txd_p), .tx_busy(busy_p), .sample_strobe(strobe_p), .uart_done(done_p));

  uart_frame_tx #(.NUM_CH(4), .CLKS_PER_BIT(4), .PERIOD_BITS(6), .PARITY_EN(0), .STOP_BITS(1)) dut_b (
    .sys_clk(clk), .sys_reset(rst), .uart_start(start_b), .ch_in(ch_b),
    .uart_txd(txd_b), .tx_busy(busy_b), .sample_strobe(strobe_b), .uart_done(done_b));

  // ---------------- reference model ----------------
  // Line level at bit-time 'pos' of a frame: start 0, data LSB first,
  // optional even parity, then stop/idle ones.
  function automatic logic exp_line(input logic [3:0] ch, input int par_en, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 4) return ch[pos-1];
    if (par_en != 0 && pos == 5) return ^ch;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (txd_a !== 1'b1 || txd_p !== 1'b1 || txd_b !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b%b%b exp 111", txd_a, txd_p, txd_b); end
    tests_run++; if (busy_a !== 1'b0 || busy_p !== 1'b0 || busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b%b%b exp 000", busy_a, busy_p, busy_b); end
    tests_run++; if (strobe_a !== 1'b0 || strobe_p !== 1'b0 || strobe_b !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe got %b%b%b exp 000", strobe_a, strobe_p, strobe_b); end
    tests_run++; if (done_a !== 1'b0 || done_p !== 1'b0 || done_b !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b%b%b exp 000", done_a, done_p, done_b); end
    @(posedge clk); #1; rst = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    tests_run++; if (txd_a !== 1'b1 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got txd=%b busy=%b exp 1/0", txd_a, busy_a); end
  endtask

  // One-cycle request, fixed pattern, inputs scrambled afterwards.
  task automatic test_single_frame();
    logic [3:0] ch;
    ch = 4'b1011;
    wait_cycles(40);
    @(posedge clk); #1; ch_a = ch; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; ch_a = 4'($urandom);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      tests_run++; if (txd_a !== exp_line(ch, 0, c / 4)) begin tests_failed++; $display("FAIL single_txd c=%0d got %b exp %b", c, txd_a, exp_line(ch, 0, c / 4)); end
      tests_run++; if (busy_a !== (c < 24)) begin tests_failed++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy_a, (c < 24)); end
      tests_run++; if (strobe_a !== (c == 0)) begin tests_failed++; $display("FAIL single_strobe c=%0d got %b exp %b", c, strobe_a, (c == 0)); end
      tests_run++; if (done_a !== (c == 23)) begin tests_failed++; $display("FAIL single_done c=%0d got %b exp %b", c, done_a, (c == 23)); end
      ch_a = 4'($urandom);
    end
  endtask

  // Held request with ch_in changing every cycle; dropped inside frame 2.
  task automatic test_periodic();
    logic [3:0] sampled, prev;
    int pos;
    logic act;
    sampled = '0;
    wait_cycles(40);
    @(posedge clk); #1; ch_a = 4'($urandom); prev = ch_a; start_a = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 112; c++) begin
      #1;
      if (c % 32 == 0 && c < 96) sampled = prev;
      if (c == 64 + 13) start_a = 1'b0;
      ch_a = 4'($urandom); prev = ch_a;
      @(negedge clk);
      pos = c % 32;
      act = (c < 96);
      tests_run++; if (txd_a !== (act ? exp_line(sampled, 0, pos / 4) : 1'b1)) begin tests_failed++; $display("FAIL periodic_txd c=%0d got %b", c, txd_a); end
      tests_run++; if (busy_a !== (act && pos < 24)) begin tests_failed++; $display("FAIL periodic_busy c=%0d got %b exp %b", c, busy_a, (act && pos < 24)); end
      tests_run++; if (strobe_a !== (act && pos == 0)) begin tests_failed++; $display("FAIL periodic_strobe c=%0d got %b exp %b", c, strobe_a, (act && pos == 0)); end
      tests_run++; if (done_a !== (act && pos == 23)) begin tests_failed++; $display("FAIL periodic_done c=%0d got %b exp %b", c, done_a, (act && pos == 23)); end
      @(posedge clk);
    end
  endtask

  // Even parity on a 7-bit frame.
  task automatic test_parity();
    logic [3:0] vec [4];
    vec[0] = 4'b0111; vec[1] = 4'b0011; vec[2] = 4'($urandom); vec[3] = 4'($urandom);
    for (int v = 0; v < 4; v++) begin
      wait_cycles(4);
      @(posedge clk); #1; ch_p = vec[v]; start_p = 1'b1;
      @(posedge clk); #1; start_p = 1'b0; ch_p = ~vec[v];
      for (int c = 0; c < 36; c++) begin
        @(negedge clk);
        tests_run++; if (txd_p !== exp_line(vec[v], 1, c / 4)) begin tests_failed++; $display("FAIL parity_txd ch=%b c=%0d got %b exp %b", vec[v], c, txd_p, exp_line(vec[v], 1, c / 4)); end
        tests_run++; if (busy_p !== (c < 28)) begin tests_failed++; $display("FAIL parity_busy c=%0d got %b exp %b", c, busy_p, (c < 28)); end
        tests_run++; if (strobe_p !== (c == 0)) begin tests_failed++; $display("FAIL parity_strobe c=%0d got %b exp %b", c, strobe_p, (c == 0)); end
        tests_run++; if (done_p !== (c == 27)) begin tests_failed++; $display("FAIL parity_done c=%0d got %b exp %b", c, done_p, (c == 27)); end
      end
    end
  endtask

  // Period equals frame length: start bit directly follows stop bit.
  task automatic test_back_to_back();
    logic [3:0] sampled, prev;
    int pos;
    logic act;
    sampled = '0;
    wait_cycles(4);
    @(posedge clk); #1; ch_b = 4'($urandom); prev = ch_b; start_b = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 96; c++) begin
      #1;
      if (c % 24 == 0 && c < 72) sampled = prev;
      if (c == 48 + 10) start_b = 1'b0;
      ch_b = 4'($urandom); prev = ch_b;
      @(negedge clk);
      pos = c % 24;
      act = (c < 72);
      tests_run++; if (txd_b !== (act ? exp_line(sampled, 0, pos / 4) : 1'b1)) begin tests_failed++; $display("FAIL b2b_txd c=%0d got %b", c, txd_b); end
      tests_run++; if (busy_b !== act) begin tests_failed++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy_b, act); end
      tests_run++; if (strobe_b !== (act && pos == 0)) begin tests_failed++; $display("FAIL b2b_strobe c=%0d got %b exp %b", c, strobe_b, (act && pos == 0)); end
      tests_run++; if (done_b !== (act && pos == 23)) begin tests_failed++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done_b, (act && pos == 23)); end
      @(posedge clk);
    end
  endtask

  // Request dropped during data bit 2: frame completes, then idle.
  task automatic test_stop_mid_frame();
    logic [3:0] ch;
    ch = 4'($urandom);
    wait_cycles(40);
    @(posedge clk); #1; ch_a = ch; start_a = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 72; c++) begin
      #1;
      if (c == 13) start_a = 1'b0;
      @(negedge clk);
      tests_run++; if (txd_a !== exp_line(ch, 0, c / 4)) begin tests_failed++; $display("FAIL stopmid_txd c=%0d got %b exp %b", c, txd_a, exp_line(ch, 0, c / 4)); end
      tests_run++; if (busy_a !== (c < 24)) begin tests_failed++; $display("FAIL stopmid_busy c=%0d got %b exp %b", c, busy_a, (c < 24)); end
      tests_run++; if (strobe_a !== (c == 0)) begin tests_failed++; $display("FAIL stopmid_strobe c=%0d got %b exp %b", c, strobe_a, (c == 0)); end
      @(posedge clk);
    end
  endtask

  // Async reset during data bit 1, then a clean frame.
  task automatic test_reset_mid_frame();
    logic [3:0] ch;
    ch = 4'($urandom) & 4'b1101;   // data bit 1 low so the line is low when reset hits
    wait_cycles(40);
    @(posedge clk); #1; ch_a = ch; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (9) @(negedge clk);   // cycle 8 = first cycle of data bit 1
    @(negedge clk);              // cycle 9
    tests_run++; if (txd_a !== 1'b0 || busy_a !== 1'b1) begin tests_failed++; $display("FAIL rstmid_before got txd=%b busy=%b exp 0/1", txd_a, busy_a); end
    #1; rst = 1'b1;
    #1;
    tests_run++; if (txd_a !== 1'b1) begin tests_failed++; $display("FAIL rstmid_txd got %b exp 1", txd_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", busy_a); end
    @(posedge clk); #1; rst = 1'b0;
    wait_cycles(3);
    ch = 4'($urandom);
    @(posedge clk); #1; ch_a = ch; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      tests_run++; if (txd_a !== exp_line(ch, 0, c / 4)) begin tests_failed++; $display("FAIL rstmid_frame_txd c=%0d got %b exp %b", c, txd_a, exp_line(ch, 0, c / 4)); end
      tests_run++; if (done_a !== (c == 23)) begin tests_failed++; $display("FAIL rstmid_frame_done c=%0d got %b exp %b", c, done_a, (c == 23)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_periodic();
    test_parity();
    test_back_to_back();
    test_stop_mid_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    tests_failed++;
    $display("FAIL timeout tests_run=%0d", tests_run);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "time limit");
  end

endmodule
